adc_capture: RTL
================

# adc_capture

Parametrised multi-channel capture front end for AD9226-class parallel ADCs. It generates the ADC sample clock from `clk_in`, captures each lane's sample word and optionally corrects board-level bit-order swaps. It then applies a per-channel signed offset with saturation, averages 2^AVG_LOG2 samples, and presents the result on a valid/ready interface. It sits between the ADC pins and the audio/DSP chain in the voice transmitter.

## Interface
- `DATA_W`, 12: sample width per channel (straight binary).
- `CH_NUM`, 1: channel count; all lanes share one sample strobe.
- `SAMP_DIV`, 1: clk_in cycles per sample, ≥1.
- `AVG_LOG2`, 0: log2 of samples averaged per output, 0..4.
- `clk_in  input  1`: system clock; all logic on its rising edge.
- `rst_n  input  1`: synchronous, active-low reset.
- `ad_data  input  CH_NUM*DATA_W`: raw ADC lanes; channel k occupies bits [k*DATA_W +: DATA_W].
- `ch_offset  input  CH_NUM*DATA_W`: per-channel signed two's-complement offset, same packing.
- `ad_clk  output  1`: clock driven to the ADC(s).
- `wave_ch  output  CH_NUM*DATA_W`: averaged, offset-corrected samples.
- `wave_valid  output  1`: wave_ch holds an unconsumed result.
- `wave_ready  input  1`: consumer accepts when high together with wave_valid.
- `ovf  output  1`: sticky; set when a result is dropped.

## Operation
- Divider `div_cnt` counts 0..SAMP_DIV-1 and wraps. The strobe is `div_cnt==SAMP_DIV-1`. With SAMP_DIV==1 the strobe is every cycle.
- ad_clk:
  - SAMP_DIV==1: `ad_clk = clk_in` (direct forward).
  - Otherwise: registered, high while `div_cnt >= SAMP_DIV/2`.
- Stage 1 (capture): on strobe, latch every lane into `cap`, with optional bit reversal (see Configuration). Set `cap_vld` for one cycle.
- Stage 2 (offset): `sat = clamp(cap + ch_offset, 0, 2^DATA_W-1)`, computed in DATA_W+2 bits signed. No wrap-around.
- Stage 3 (average): per-channel accumulator of DATA_W+AVG_LOG2 bits and shared counter `avg_cnt`.
  - On the 2^AVG_LOG2-th stage-2 sample, the result is `(acc + sat) >> AVG_LOG2` (truncating).
  - The accumulator restarts at 0 on the same edge.
- Output buffer (single entry):
  - Loading a result sets wave_valid.
  - A handshake (`valid && ready`) clears wave_valid unless a new result loads on the same edge. In that case the new result loads and wave_valid stays high.
  - A result arriving while wave_valid=1 and wave_ready=0 is dropped, the old data is held, and ovf is set. ovf is cleared only by reset.
- wave_ch does not change while wave_valid=1 and wave_ready=0.

## Timing
- Reset values: div_cnt=0, ad_clk=0 (divided mode), cap=0, sat=0, acc=0, avg_cnt=0, wave_ch=0, wave_valid=0, ovf=0.
- Reset mid-average discards the partial accumulation. The first strobe after reset is at cycle SAMP_DIV-1.
- Latency with AVG_LOG2=0: sample captured at edge N, wave_valid high after edge N+2.
- Latency with AVG_LOG2>0: wave_valid high 2 edges after the capture of the last sample in the window.
- Output rate: one result per SAMP_DIV·2^AVG_LOG2 cycles. wave_ready held high never causes ovf.
- ch_offset is sampled in stage 2. A change affects samples passing stage 2 afterwards; no glitching of held output.

## Configuration
- `ADC_BIT_REVERSE_EN` defined: each lane's DATA_W bits are reversed at capture (bit i → bit DATA_W-1-i), for boards wiring the ADC MSB to lane bit 0.
- Undefined: lanes are captured unchanged.

## Structure
- Package `adc_pkg`:
  - `AVG_LOG2_MAX=4`.
  - Saturation-clamp function.
  - Lane-slice helper constants.
- Sub-module `adc_lane`, one per channel via generate, containing:
  - capture with reversal,
  - offset/saturate,
  - accumulator.
- The top level holds the divider, ad_clk, avg_cnt, output buffer and ovf.

## Test plan
- Defaults, SAMP_DIV=1, ch_offset=27, ad_data=100 (macro undefined) → wave_ch=127, wave_valid high 2 cycles after capture, one result per cycle with ready=1.
- ADC_BIT_REVERSE_EN defined, ad_data=12'h001, offset 0 → wave_ch=12'h800.
- Saturation: ad_data=4090, offset +27 → 4095; ad_data=5, offset −27 → 0.
- AVG_LOG2=2, SAMP_DIV=4, samples 10, 11, 12, 14, offset 0 → single result 11; next result 16 cycles later; ad_clk period 4, high 2.
- Backpressure: wave_ready=0 across two results → first result held unchanged, second dropped, ovf=1. Then ready=1 → handshake, ovf stays 1.
- CH_NUM=2, offsets 27/−3, lanes 100/50 → wave_ch = {47,127}. Reset asserted mid-window → all outputs 0 and next result uses only post-reset samples.

Source files
------------

// File: rtl/adc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_pkg : shared constants and helpers for the adc_capture front end     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package adc_pkg;

   localparam int AVG_LOG2_MAX = 4;

   // Bit position of channel k inside a packed multi-lane bus
   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction

   // Clamp a signed value into the unsigned range [0, 2^w-1]
   function automatic logic [31:0] sat_clamp(input logic signed [33:0] v, input int unsigned w);
      logic signed [33:0] hi;
      hi = (34'sd1 <<< w) - 34'sd1;
      if (v < 34'sd0)
         sat_clamp = '0;
      else if (v > hi)
         sat_clamp = hi[31:0];
      else
         sat_clamp = v[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_lane : one channel - capture (ADC_BIT_REVERSE_EN), offset/sat, avg   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module adc_lane
   import adc_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 0
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              cap_en,
   input  logic              sat_en,
   input  logic              acc_en,
   input  logic              acc_last,
   input  logic [DATA_W-1:0] lane_in,
   input  logic [DATA_W-1:0] offset_in,
   output logic [DATA_W-1:0] result
);

   localparam int ACC_W = DATA_W + AVG_LOG2;

   logic [DATA_W-1:0]        lane_cap;
   logic [DATA_W-1:0]        cap_q, cap_d;
   logic [DATA_W-1:0]        sat_q, sat_d;
   logic [ACC_W-1:0]         acc_q, acc_d;
   logic [ACC_W-1:0]         acc_sum;
   logic signed [DATA_W+1:0] sum;

`ifdef ADC_BIT_REVERSE_EN
   always_comb begin
      lane_cap = '0;
      for (int i = 0; i < DATA_W; i++)
         lane_cap[i] = lane_in[DATA_W-1-i];
   end
`else
   assign lane_cap = lane_in;
`endif

   always_comb begin
      cap_d   = cap_en ? lane_cap : cap_q;
      // Two guard bits keep the signed sum free of wrap-around before clamping
      sum     = $signed({2'b00, cap_q}) + $signed({{2{offset_in[DATA_W-1]}}, offset_in});
      sat_d   = sat_en ? DATA_W'(sat_clamp(34'(sum), DATA_W)) : sat_q;
      acc_sum = acc_q + ACC_W'(sat_q);
      acc_d   = acc_q;
      if (acc_en)
         acc_d = acc_last ? '0 : acc_sum;
   end

   assign result = acc_sum[ACC_W-1:AVG_LOG2];

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cap_q <= '0;
         sat_q <= '0;
         acc_q <= '0;
      end else begin
         cap_q <= cap_d;
         sat_q <= sat_d;
         acc_q <= acc_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_capture : multi-lane ADC front end, divider + averaging + out buffer |
// | Rev 1.0  (optional lane bit reversal: ADC_BIT_REVERSE_EN)                |
// +--------------------------------------------------------------------------+
module adc_capture
   import adc_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int CH_NUM   = 1,
   parameter int SAMP_DIV = 1,
   parameter int AVG_LOG2 = 0
) (
   input  logic                     clk_in,
   input  logic                     rst_n,
   input  logic [CH_NUM*DATA_W-1:0] ad_data,
   input  logic [CH_NUM*DATA_W-1:0] ch_offset,
   output logic                     ad_clk,
   output logic [CH_NUM*DATA_W-1:0] wave_ch,
   output logic                     wave_valid,
   input  logic                     wave_ready,
   output logic                     ovf
);

   localparam int              DIV_W    = (SAMP_DIV > 1) ? $clog2(SAMP_DIV) : 1;
   localparam int              CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMP_DIV - 1);
   localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
   logic                     strobe;
   logic                     cap_vld_q, cap_vld_d;
   logic                     sat_vld_q, sat_vld_d;
   logic [CNT_W-1:0]         avg_cnt_q, avg_cnt_d;
   logic                     avg_last;
   logic                     res_vld;
   logic                     res_load;
   logic [CH_NUM*DATA_W-1:0] res_ch;
   logic [CH_NUM*DATA_W-1:0] wave_ch_q, wave_ch_d;
   logic                     wave_valid_q, wave_valid_d;
   logic                     ovf_q, ovf_d;

   generate
      for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
         adc_lane #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2)
         ) u_lane (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .cap_en    (strobe),
            .sat_en    (cap_vld_q),
            .acc_en    (sat_vld_q),
            .acc_last  (avg_last),
            .lane_in   (ad_data[lane_lsb(k, DATA_W) +: DATA_W]),
            .offset_in (ch_offset[lane_lsb(k, DATA_W) +: DATA_W]),
            .result    (res_ch[lane_lsb(k, DATA_W) +: DATA_W])
         );
      end
   endgenerate

   always_comb begin
      strobe    = (div_cnt_q == DIV_LAST);
      div_cnt_d = strobe ? '0 : div_cnt_q + DIV_W'(1);
      cap_vld_d = strobe;
      sat_vld_d = cap_vld_q;
      avg_last  = (avg_cnt_q == AVG_LAST);
      avg_cnt_d = avg_cnt_q;
      if (sat_vld_q)
         avg_cnt_d = avg_last ? '0 : avg_cnt_q + CNT_W'(1);
      res_vld      = sat_vld_q && avg_last;
      // A result is taken when the buffer is empty or being drained this edge
      res_load     = res_vld && (!wave_valid_q || wave_ready);
      wave_ch_d    = res_load ? res_ch : wave_ch_q;
      wave_valid_d = res_load || (wave_valid_q && !wave_ready);
      ovf_d        = ovf_q || (res_vld && wave_valid_q && !wave_ready);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         div_cnt_q    <= '0;
         cap_vld_q    <= 1'b0;
         sat_vld_q    <= 1'b0;
         avg_cnt_q    <= '0;
         wave_ch_q    <= '0;
         wave_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         cap_vld_q    <= cap_vld_d;
         sat_vld_q    <= sat_vld_d;
         avg_cnt_q    <= avg_cnt_d;
         wave_ch_q    <= wave_ch_d;
         wave_valid_q <= wave_valid_d;
         ovf_q        <= ovf_d;
      end
   end

   generate
      if (SAMP_DIV == 1) begin : g_clk_fwd
         assign ad_clk = clk_in;
      end else begin : g_clk_div
         logic ad_clk_q, ad_clk_d;
         always_comb ad_clk_d = (div_cnt_d >= DIV_W'(SAMP_DIV / 2));
         always_ff @(posedge clk_in) begin
            if (!rst_n)
               ad_clk_q <= 1'b0;
            else
               ad_clk_q <= ad_clk_d;
         end
         assign ad_clk = ad_clk_q;
      end
   endgenerate

   assign wave_ch    = wave_ch_q;
   assign wave_valid = wave_valid_q;
   assign ovf        = ovf_q;

endmodule
`default_nettype wire
